// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster engine.
// Divides the system clock down to a pixel-rate enable, walks the horizontal and
// vertical counters, hands pixel coordinates to the scene logic and registers
// sync and blanked colour one pixel later.
// Optional feature: define VGA_TEST_PATTERN_EN to build an eight-bar colour test
// pattern that replaces r_in/g_in/b_in while pattern_sel is high.
module vga_timing_gen #(
   parameter int PIX_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = 4,
   parameter int XW       = 10,
   parameter int YW       = 10
) (
   input  logic          clk,
   input  logic          clrn,
   input  logic          en,
   input  logic [CW-1:0] r_in,
   input  logic [CW-1:0] g_in,
   input  logic [CW-1:0] b_in,
   input  logic          pattern_sel,
   output logic [XW-1:0] pix_x,
   output logic [YW-1:0] pix_y,
   output logic          pix_valid,
   output logic          pix_tick,
   output logic          line_start,
   output logic          frame_start,
   output logic          hsync,
   output logic          vsync,
   output logic [CW-1:0] r,
   output logic [CW-1:0] g,
   output logic [CW-1:0] b
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST     = DW'(PIX_DIV - 1);
   localparam logic [XW-1:0] H_LAST       = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] V_LAST       = YW'(V_TOTAL - 1);
   localparam logic [XW-1:0] H_VIS_END    = XW'(H_ACTIVE);
   localparam logic [YW-1:0] V_VIS_END    = YW'(V_ACTIVE);
   localparam logic [XW-1:0] H_SYNC_START = XW'(H_ACTIVE + H_FP);
   localparam logic [XW-1:0] H_SYNC_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [YW-1:0] V_SYNC_START = YW'(V_ACTIVE + V_FP);
   localparam logic [YW-1:0] V_SYNC_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] div;
   logic [XW-1:0] h_cnt;
   logic [YW-1:0] v_cnt;
   logic          h_wrap;
   logic          v_wrap;
   logic          in_hsync;
   logic          in_vsync;
   logic [CW-1:0] src_r;
   logic [CW-1:0] src_g;
   logic [CW-1:0] src_b;

   // Pixel-rate enable: one system clock in every PIX_DIV while running.
   assign pix_tick    = en && (div == DIV_LAST);
   assign h_wrap      = (h_cnt == H_LAST);
   assign v_wrap      = (v_cnt == V_LAST);
   assign line_start  = pix_tick && (h_cnt == '0);
   assign frame_start = line_start && (v_cnt == '0);

   assign pix_x     = h_cnt;
   assign pix_y     = v_cnt;
   assign pix_valid = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);

   assign in_hsync = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
   assign in_vsync = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

   logic [2:0] bar;

   // Bar index is the horizontal position divided by the bar width, clamped to the last bar.
   always_comb begin
      bar = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (h_cnt >= XW'(k * BAR_W)) begin
            bar = 3'(k);
         end
      end
   end

   // Bar order white, yellow, cyan, green, magenta, red, blue, black falls out of the index bits.
   always_comb begin
      src_r = r_in;
      src_g = g_in;
      src_b = b_in;
      if (pattern_sel) begin
         src_r = {CW{~bar[1]}};
         src_g = {CW{~bar[2]}};
         src_b = {CW{~bar[0]}};
      end
   end
`else
   logic pattern_sel_unused;

   assign pattern_sel_unused = pattern_sel;
   assign src_r = r_in;
   assign src_g = g_in;
   assign src_b = b_in;
`endif

   // Clock divider: free-runs 0..PIX_DIV-1 while enabled, frozen when en is low.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         div <= '0;
      end else if (en) begin
         if (div == DIV_LAST) begin
            div <= '0;
         end else begin
            div <= div + 1'b1;
         end
      end
   end

   // Raster position: h steps every pixel, v steps when h wraps, both wrap together at frame end.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_tick) begin
         if (h_wrap) begin
            h_cnt <= '0;
            if (v_wrap) begin
               v_cnt <= '0;
            end else begin
               v_cnt <= v_cnt + 1'b1;
            end
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   // Output stage: sync and blanked colour for the position just left, one pixel behind pix_x/pix_y.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         hsync <= ~HS_POL;
         vsync <= ~VS_POL;
         r     <= '0;
         g     <= '0;
         b     <= '0;
      end else if (pix_tick) begin
         hsync <= in_hsync ? HS_POL : ~HS_POL;
         vsync <= in_vsync ? VS_POL : ~VS_POL;
         r     <= pix_valid ? src_r : '0;
         g     <= pix_valid ? src_g : '0;
         b     <= pix_valid ? src_b : '0;
      end
   end

endmodule
